// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types, opcode encodings and helpers for the
//               sequential radix-2 RV32M divider (div_seq).
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand width; also the number of shift-subtract iterations.
    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // opcode[0] = unsigned, opcode[1] = remainder
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Signed overflow case: most negative dividend divided by -1.
    // Flags are passed in rather than operands so the helper is width-agnostic.
    function automatic logic is_signed_ovf(input logic is_unsigned,
                                           input logic op1_is_min,
                                           input logic op2_is_neg1);
        return ~is_unsigned & op1_is_min & op2_is_neg1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_if
// Description : Request/response bundle between the EX stage and div_seq.
//   flush                 abort any in-flight operation
//   in_valid / in_ready   request handshake (opcode, op1, op2)
//   out_valid / out_ready result handshake (result)
//   busy                  divider not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_if
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      opcode;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    // EX stage side
    modport master (
        output flush, in_valid, opcode, op1, op2, out_ready,
        input  in_ready, out_valid, result, busy
    );

    // Divider side
    modport slave (
        input  flush, in_valid, opcode, op1, op2, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration. Shifts the
//               next dividend bit into the partial remainder, trial-subtracts
//               the divisor and records the quotient bit.
//   rem   in   XLEN  partial remainder
//   quo   in   XLEN  dividend bits still to consume / quotient bits produced
//   div   in   XLEN  divisor (magnitude)
//   rem_n out  XLEN  next partial remainder
//   quo_n out  XLEN  next quotient register
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] rem,
    input  wire logic [XLEN-1:0] quo,
    input  wire logic [XLEN-1:0] div,
    output logic      [XLEN-1:0] rem_n,
    output logic      [XLEN-1:0] quo_n
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // rem < div always holds, so the shifted value is below 2*div and the
    // difference fits in XLEN+1 bits; its MSB is the borrow.
    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, div};

    assign rem_n = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_n = {quo[XLEN-2:0], ~trial[XLEN]};
endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Multicycle radix-2 restoring divider for RV32M DIV/DIVU/
//               REM/REMU. One operation in flight; divide-by-zero and signed
//               overflow complete in one cycle, all others take XLEN CALC
//               cycles plus one FIX cycle.
//   clk    in  1   clock
//   rst_b  in  1   synchronous, active-high reset
//   dif    slave modport of div_seq_if:
//          flush, in_valid, in_ready, opcode, op1, op2,
//          out_valid, out_ready, result, busy
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input wire logic clk,
    input wire logic rst_b,
    div_seq_if.slave dif
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    div_state_e      state_n;

    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;

    logic            accept;
    logic            op_is_rem;
    logic            op_is_uns;
    logic            op1_neg;
    logic            op2_neg;
    logic            div_by_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] quo_n;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // ---------------- request decode (only meaningful at accept) ----------
    assign accept      = dif.in_valid & dif.in_ready;
    assign op_is_rem   = (dif.opcode == DIV_OP_REM)  | (dif.opcode == DIV_OP_REMU);
    assign op_is_uns   = (dif.opcode == DIV_OP_DIVU) | (dif.opcode == DIV_OP_REMU);
    assign op1_neg     = ~op_is_uns & dif.op1[XLEN-1];
    assign op2_neg     = ~op_is_uns & dif.op2[XLEN-1];
    assign div_by_zero = (dif.op2 == '0);
    assign ovf         = is_signed_ovf(op_is_uns, dif.op1 == MIN_VAL, &dif.op2);
    assign special     = div_by_zero | ovf;
    assign abs1        = op1_neg ? -dif.op1 : dif.op1;
    assign abs2        = op2_neg ? -dif.op2 : dif.op2;

    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = op_is_rem ? dif.op1 : {XLEN{1'b1}};
        end else begin
            special_res = op_is_rem ? '0 : MIN_VAL;
        end
    end

    // ---------------- iteration datapath -----------------------------------
    div_step #(.XLEN(XLEN)) u_step (
        .rem   (rem),
        .quo   (quo),
        .div   (dvs),
        .rem_n (rem_n),
        .quo_n (quo_n)
    );

    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    // ---------------- FSM --------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = special ? DONE : CALC;
            CALC: if (cnt == '0) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: if (dif.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // flush wins over every other transition
        if (dif.flush) state_n = IDLE;
    end

    // ---------------- operand / result registers ---------------------------
    always_ff @(posedge clk) begin
        if (rst_b) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            result <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (!dif.flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem <= op_is_rem;
                        // quotient sign differs when exactly one operand is
                        // negative; remainder takes the dividend's sign
                        neg_q  <= op1_neg ^ op2_neg;
                        neg_r  <= op1_neg;
                        if (special) begin
                            result <= special_res;
                        end else begin
                            quo <= abs1;
                            dvs <= abs2;
                            rem <= '0;
                            cnt <= CNT_W'(XLEN - 1);
                        end
                    end
                end
                CALC: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    result <= is_rem ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------------------------------------
    assign dif.in_ready  = (state == IDLE) & ~dif.flush;
    assign dif.out_valid = (state == DONE);
    assign dif.busy      = (state != IDLE);
    assign dif.result    = result;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq
// Description : Self-checking bench for div_seq. Stimulus pushes expected
//               result/latency into a queue; a monitor pops and compares on
//               each result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;
    import div_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    div_seq_if #(.XLEN(XLEN)) dif();

    div_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .dif   (dif)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ---------------------------------
    logic prev_ov = 1'b0;
    int   ov_cyc  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_b) begin
            prev_ov = 1'b0;
        end else begin
            if (dif.out_valid && !prev_ov) ov_cyc = cyc;
            prev_ov = dif.out_valid;
            if (dif.out_valid && dif.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual=%h required=no output", dif.result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, dif.result, e.res);
                    check({e.name, "_latency"}, 32'(ov_cyc - e.acc + 1), 32'(e.lat));
                end
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input string nm, input logic [1:0] opc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat,
                         input bit push, output int acc);
        bit ok;
        exp_t e;
        ok  = 1'b0;
        acc = -1;
        dif.opcode   = opc;
        dif.op1      = a;
        dif.op2      = b;
        dif.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dif.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            acc = cyc + 1;
            if (push) begin
                e.name = nm; e.res = res; e.lat = lat; e.acc = acc;
                sb.push_back(e);
            end
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept: actual=no in_ready required=accept within 100 cycles", nm);
        end
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        // later operand changes must not disturb the in-flight operation
        dif.op1      = $urandom;
        dif.op2      = $urandom;
        dif.opcode   = 2'($urandom);
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !dif.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_drained"}, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ---------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------------------------------
    initial begin
        int acc;
        int acc2;
        int h;
        bit ok;
        bit seen;

        dif.flush     = 1'b0;
        dif.in_valid  = 1'b0;
        dif.opcode    = 2'b00;
        dif.op1       = '0;
        dif.op2       = '0;
        dif.out_ready = 1'b1;
        rst_b         = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  32'(dif.in_ready),  32'd1);
        check("reset_out_valid", 32'(dif.out_valid), 32'd0);
        check("reset_busy",      32'(dif.busy),      32'd0);
        check("reset_result",    dif.result,         32'd0);
        @(posedge clk);
        #1;

        // directed vectors
        issue("divu_100_7",  DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         34, 1, acc);
        issue("remu_100_7",  DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          34, 1, acc);
        issue("div_m7_2",    DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 1, acc);
        issue("rem_m7_2",    DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 1, acc);
        issue("div_7_m2",    DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, 1, acc);
        issue("rem_7_m2",    DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, 1, acc);
        issue("div_5_0",     DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,   1, 1, acc);
        issue("rem_5_0",     DIV_OP_REM,  32'd5,          32'd0,          32'd5,           1, 1, acc);
        issue("divu_5_0",    DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,   1, 1, acc);
        issue("remu_5_0",    DIV_OP_REMU, 32'd5,          32'd0,          32'd5,           1, 1, acc);
        issue("div_ovf",     DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1, 1, acc);
        issue("rem_ovf",     DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           1, 1, acc);
        issue("divu_min_m1", DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, 1, acc);
        issue("remu_min_m1", DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34, 1, acc);
        issue("divu_max_1",  DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 1, acc);
        issue("rem_m100_m7", DIV_OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  34, 1, acc);
        drain("directed");

        // result held while out_ready is low, then back-to-back issue
        dif.out_ready = 1'b0;
        issue("hold_divu", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1, acc);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dif.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("hold_reached_done", 32'(ok), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", 32'(dif.out_valid), 32'd1);
            check("hold_result",    dif.result,         32'd14);
            check("hold_in_ready",  32'(dif.in_ready),  32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        dif.out_ready = 1'b1;
        h = cyc + 1;
        issue("b2b_div", DIV_OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34, 1, acc2);
        check("b2b_accept_edge", 32'(acc2), 32'(h + 1));
        drain("b2b");

        // flush during CALC; a request presented under flush is not taken
        issue("flush_op", DIV_OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 0, acc);
        repeat (4) @(posedge clk);
        #1;
        check("flush_pre_busy", 32'(dif.busy), 32'd1);
        dif.flush    = 1'b1;
        dif.in_valid = 1'b1;
        dif.opcode   = DIV_OP_DIVU;
        dif.op1      = 32'd9;
        dif.op2      = 32'd3;
        @(negedge clk);
        check("flush_in_ready", 32'(dif.in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("flush_busy",      32'(dif.busy),      32'd0);
        check("flush_out_valid", 32'(dif.out_valid), 32'd0);
        @(posedge clk);
        #1;
        dif.flush    = 1'b0;
        dif.in_valid = 1'b0;
        @(negedge clk);
        check("flush_no_accept", 32'(dif.busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dif.out_valid) seen = 1'b1;
        end
        check("flush_no_result", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        // reset during CALC clears everything, including the held result
        issue("reset_op", DIV_OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 0, acc);
        repeat (4) @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 32'(dif.out_valid), 32'd0);
        check("midreset_result",    dif.result,         32'd0);
        check("midreset_busy",      32'(dif.busy),      32'd0);
        check("midreset_in_ready",  32'(dif.in_ready),  32'd1);
        @(posedge clk);
        #1;

        issue("post_reset_remu", DIV_OP_REMU, 32'd1000, 32'd3, 32'd1, 34, 1, acc);
        drain("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
